// File: rtl/wb_arbiter_if.sv
// Writeback bus between the three result producers, issue logic and the arbiter.
// The master side drives requests and issue info; the slave side is the arbiter.
interface wb_arbiter_if #(
  parameter int unsigned XLEN = 32
);
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;

  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;

  logic            mdu_valid;
  logic            mdu_ready;
  logic [4:0]      mdu_rd;
  logic [XLEN-1:0] mdu_data;

  logic            iss_valid;
  logic [4:0]      iss_rd;

  logic [31:0]     pending;
  logic            rf_write;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output mdu_valid, mdu_rd, mdu_data,
    output iss_valid, iss_rd,
    input  alu_ready, lsu_ready, mdu_ready,
    input  pending, rf_write, rf_waddr, rf_wdata
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  mdu_valid, mdu_rd, mdu_data,
    input  iss_valid, iss_rd,
    output alu_ready, lsu_ready, mdu_ready,
    output pending, rf_write, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: grants one of ALU/LSU/MDU per cycle with starvation promotion,
// drives the register-file write port and keeps the per-register pending scoreboard.
module wb_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);
  localparam int unsigned CW   = 4;
  localparam int unsigned RW   = 5;
  localparam int unsigned NREG = 32;

  logic [CW-1:0]   lsu_wait, mdu_wait;
  logic [CW-1:0]   lsu_wait_nxt, mdu_wait_nxt;
  logic            lsu_urgent_c, mdu_urgent_c;
  logic            alu_gnt_c, lsu_gnt_c, mdu_gnt_c, any_gnt_c;
  logic [RW-1:0]   gnt_rd_c;
  logic [XLEN-1:0] gnt_data_c;
  logic [NREG-1:0] pending_q, pending_nxt;
  logic            rf_write_q;
  logic [RW-1:0]   rf_waddr_q;
  logic [XLEN-1:0] rf_wdata_q;

  assign lsu_urgent_c = bus.lsu_valid && (lsu_wait == CW'(STARVE_LIMIT));
  assign mdu_urgent_c = bus.mdu_valid && (mdu_wait == CW'(STARVE_LIMIT));

  // Fixed priority with urgent promotion; nothing is granted while reset is held
  always_comb begin
    alu_gnt_c  = 1'b0;
    lsu_gnt_c  = 1'b0;
    mdu_gnt_c  = 1'b0;
    gnt_rd_c   = '0;
    gnt_data_c = '0;
    if (!rst) begin
      alu_gnt_c = 1'b0;
    end else if (mdu_urgent_c) begin
      mdu_gnt_c = 1'b1;
    end else if (lsu_urgent_c) begin
      lsu_gnt_c = 1'b1;
    end else if (bus.alu_valid) begin
      alu_gnt_c = 1'b1;
    end else if (bus.lsu_valid) begin
      lsu_gnt_c = 1'b1;
    end else if (bus.mdu_valid) begin
      mdu_gnt_c = 1'b1;
    end
    if (alu_gnt_c) begin
      gnt_rd_c   = bus.alu_rd;
      gnt_data_c = bus.alu_data;
    end else if (lsu_gnt_c) begin
      gnt_rd_c   = bus.lsu_rd;
      gnt_data_c = bus.lsu_data;
    end else if (mdu_gnt_c) begin
      gnt_rd_c   = bus.mdu_rd;
      gnt_data_c = bus.mdu_data;
    end
  end

  assign any_gnt_c     = alu_gnt_c || lsu_gnt_c || mdu_gnt_c;
  assign bus.alu_ready = alu_gnt_c;
  assign bus.lsu_ready = lsu_gnt_c;
  assign bus.mdu_ready = mdu_gnt_c;

  // Wait counters count stalled cycles, saturate at the limit, clear on grant or idle
  always_comb begin
    lsu_wait_nxt = '0;
    mdu_wait_nxt = '0;
    if (bus.lsu_valid && !lsu_gnt_c) begin
      lsu_wait_nxt = (lsu_wait == CW'(STARVE_LIMIT)) ? lsu_wait : lsu_wait + CW'(1);
    end
    if (bus.mdu_valid && !mdu_gnt_c) begin
      mdu_wait_nxt = (mdu_wait == CW'(STARVE_LIMIT)) ? mdu_wait : mdu_wait + CW'(1);
    end
  end

  // Commit clears the in-flight bit; a same-edge issue of that register wins
  always_comb begin
    pending_nxt = pending_q;
    if (rf_write_q) begin
      pending_nxt[rf_waddr_q] = 1'b0;
    end
    if (bus.iss_valid && (bus.iss_rd != RW'(0))) begin
      pending_nxt[bus.iss_rd] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lsu_wait   <= '0;
      mdu_wait   <= '0;
      pending_q  <= '0;
      rf_write_q <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      lsu_wait   <= lsu_wait_nxt;
      mdu_wait   <= mdu_wait_nxt;
      pending_q  <= pending_nxt;
      rf_write_q <= any_gnt_c && (gnt_rd_c != RW'(0));
      if (any_gnt_c) begin
        rf_waddr_q <= gnt_rd_c;
        rf_wdata_q <= gnt_data_c;
      end
    end
  end

  assign bus.pending  = pending_q;
  assign bus.rf_write = rf_write_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed table, hand sequences and random
// traffic compared against a behavioural model of the arbitration rules.
module tb_wb_arbiter;
  localparam int unsigned XLEN  = 32;
  localparam int          LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_arbiter_if #(.XLEN(XLEN)) bus ();

  wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model state: source index 0 none, 1 ALU, 2 LSU, 3 MDU
  bit        m_write;
  bit [4:0]  m_waddr;
  bit [31:0] m_wdata;
  bit        m_pend[32];
  int        m_lsu_w, m_mdu_w;
  logic [2:0] last_rdy;

  typedef struct {
    logic       alu_v;
    logic       lsu_v;
    logic       mdu_v;
    logic [2:0] exp_rdy;
  } vec_t;
  vec_t tbl[17];

  function automatic vec_t mk(logic a, logic l, logic m, logic [2:0] e);
    vec_t v;
    v.alu_v = a; v.lsu_v = l; v.mdu_v = m; v.exp_rdy = e;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_write = 1'b0; m_waddr = '0; m_wdata = '0;
    m_lsu_w = 0; m_mdu_w = 0;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
  endtask

  function automatic int model_grant();
    if (bus.mdu_valid && m_mdu_w == LIMIT) return 3;
    if (bus.lsu_valid && m_lsu_w == LIMIT) return 2;
    if (bus.alu_valid) return 1;
    if (bus.lsu_valid) return 2;
    if (bus.mdu_valid) return 3;
    return 0;
  endfunction

  // Called just after a falling edge with inputs applied; returns at the next falling edge
  task automatic cycle();
    int          g;
    logic [2:0]  exp_r;
    logic [31:0] pv;
    bit [4:0]    rd;
    bit [31:0]   data;
    #1;
    g = model_grant();
    exp_r = (g == 1) ? 3'b001 : (g == 2) ? 3'b010 : (g == 3) ? 3'b100 : 3'b000;
    last_rdy = {bus.mdu_ready, bus.lsu_ready, bus.alu_ready};
    for (int i = 0; i < 32; i++) pv[i] = m_pend[i];
    check("ready", 32'(last_rdy), 32'(exp_r));
    check("ready_onehot", 32'($onehot0(last_rdy)), 32'(1));
    check("rf_write", 32'(bus.rf_write), 32'(m_write));
    check("rf_waddr", 32'(bus.rf_waddr), 32'(m_waddr));
    check("rf_wdata", bus.rf_wdata, m_wdata);
    check("pending", bus.pending, pv);
    rd   = (g == 1) ? bus.alu_rd : (g == 2) ? bus.lsu_rd : bus.mdu_rd;
    data = (g == 1) ? bus.alu_data : (g == 2) ? bus.lsu_data : bus.mdu_data;
    if (m_write) m_pend[m_waddr] = 1'b0;
    if (bus.iss_valid && bus.iss_rd != 0) m_pend[bus.iss_rd] = 1'b1;
    m_lsu_w = (bus.lsu_valid && g != 2) ? ((m_lsu_w + 1 > LIMIT) ? LIMIT : m_lsu_w + 1) : 0;
    m_mdu_w = (bus.mdu_valid && g != 3) ? ((m_mdu_w + 1 > LIMIT) ? LIMIT : m_mdu_w + 1) : 0;
    m_write = (g != 0) && (rd != 0);
    if (g != 0) begin
      m_waddr = rd;
      m_wdata = data;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0; bus.mdu_valid = 1'b0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0;
  endtask

  initial begin
    tbl[0]  = mk(1, 1, 0, 3'b001);
    tbl[1]  = mk(1, 1, 0, 3'b001);
    tbl[2]  = mk(1, 1, 0, 3'b001);
    tbl[3]  = mk(1, 1, 0, 3'b001);
    tbl[4]  = mk(1, 1, 0, 3'b010);
    tbl[5]  = mk(1, 1, 0, 3'b001);
    tbl[6]  = mk(0, 0, 0, 3'b000);
    tbl[7]  = mk(1, 1, 1, 3'b001);
    tbl[8]  = mk(1, 1, 1, 3'b001);
    tbl[9]  = mk(1, 1, 1, 3'b001);
    tbl[10] = mk(1, 1, 1, 3'b001);
    tbl[11] = mk(1, 1, 1, 3'b100);
    tbl[12] = mk(1, 1, 1, 3'b010);
    tbl[13] = mk(1, 1, 1, 3'b001);
    tbl[14] = mk(0, 1, 1, 3'b010);
    tbl[15] = mk(0, 0, 1, 3'b100);
    tbl[16] = mk(0, 0, 0, 3'b000);

    // Reset held with every request active
    rst = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h0000_00A1;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h0000_0011;
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd9; bus.mdu_data = 32'h0000_00D1;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd5;
    model_reset();
    @(negedge clk); @(negedge clk);
    #1;
    check("rst_ready", 32'({bus.mdu_ready, bus.lsu_ready, bus.alu_ready}), 32'(0));
    check("rst_rf_write", 32'(bus.rf_write), 32'(0));
    check("rst_rf_waddr", 32'(bus.rf_waddr), 32'(0));
    check("rst_rf_wdata", bus.rf_wdata, 32'(0));
    check("rst_pending", bus.pending, 32'(0));
    @(negedge clk);
    rst = 1'b1;
    bus.iss_valid = 1'b0;
    cycle();
    check("first_grant_alu", 32'(last_rdy), 32'(3'b001));

    // Single ALU write and its one-cycle latency
    idle_inputs();
    cycle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'hDEAD_BEEF;
    cycle();
    check("alu_ready", 32'(last_rdy), 32'(3'b001));
    check("alu_rf_write", 32'(bus.rf_write), 32'(1));
    check("alu_rf_waddr", 32'(bus.rf_waddr), 32'(3));
    check("alu_rf_wdata", bus.rf_wdata, 32'hDEAD_BEEF);
    idle_inputs();
    cycle();
    check("alu_rf_write_off", 32'(bus.rf_write), 32'(0));

    // Scoreboard: issue, commit, and same-edge reissue
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    cycle();
    idle_inputs();
    check("pend9_set", 32'(bus.pending[9]), 32'(1));
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd9; bus.mdu_data = 32'h0000_1234;
    cycle();
    idle_inputs();
    check("pend9_hold_m1", 32'(bus.pending[9]), 32'(1));
    cycle();
    check("pend9_clear_m2", 32'(bus.pending[9]), 32'(0));
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    cycle();
    bus.iss_valid = 1'b0;
    bus.mdu_valid = 1'b1;
    cycle();
    idle_inputs();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    cycle();
    idle_inputs();
    check("pend9_set_wins", 32'(bus.pending[9]), 32'(1));
    cycle();
    check("pend9_still_set", 32'(bus.pending[9]), 32'(1));

    // x0 writes and x0 issue are invisible
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'h0000_FFFF;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
    cycle();
    check("x0_lsu_ready", 32'(last_rdy), 32'(3'b010));
    idle_inputs();
    check("x0_rf_write", 32'(bus.rf_write), 32'(0));
    check("x0_pending0", 32'(bus.pending[0]), 32'(0));
    cycle();

    // Starvation table, starting from cleared counters
    bus.alu_rd = 5'd3; bus.alu_data = 32'hDEAD_BEEF;
    bus.lsu_rd = 5'd7; bus.lsu_data = 32'h0000_0011;
    bus.mdu_rd = 5'd12; bus.mdu_data = 32'h0000_0077;
    foreach (tbl[i]) begin
      bus.alu_valid = tbl[i].alu_v;
      bus.lsu_valid = tbl[i].lsu_v;
      bus.mdu_valid = tbl[i].mdu_v;
      cycle();
      check($sformatf("tbl_ready_%0d", i), 32'(last_rdy), 32'(tbl[i].exp_rdy));
    end

    // Random traffic; stalled requests keep valid, rd and data stable
    for (int n = 0; n < 400; n++) begin
      if (!(bus.alu_valid && !last_rdy[0])) begin
        bus.alu_valid = ($urandom_range(0, 9) < 6);
        bus.alu_rd = 5'($urandom_range(0, 31)); bus.alu_data = $urandom;
      end
      if (!(bus.lsu_valid && !last_rdy[1])) begin
        bus.lsu_valid = ($urandom_range(0, 9) < 6);
        bus.lsu_rd = 5'($urandom_range(0, 31)); bus.lsu_data = $urandom;
      end
      if (!(bus.mdu_valid && !last_rdy[2])) begin
        bus.mdu_valid = ($urandom_range(0, 9) < 5);
        bus.mdu_rd = 5'($urandom_range(0, 31)); bus.mdu_data = $urandom;
      end
      bus.iss_valid = ($urandom_range(0, 9) < 4);
      bus.iss_rd = 5'($urandom_range(0, 31));
      cycle();
    end

    // Reset arriving between grant and commit discards the write
    idle_inputs();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h0000_00AA;
    #1;
    check("midrst_pre_ready", 32'(bus.alu_ready), 32'(1));
    rst = 1'b0;
    #1;
    check("midrst_ready", 32'({bus.mdu_ready, bus.lsu_ready, bus.alu_ready}), 32'(0));
    @(posedge clk);
    #1;
    check("midrst_rf_write", 32'(bus.rf_write), 32'(0));
    check("midrst_pending", bus.pending, 32'(0));
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    idle_inputs();
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-side companion to the integer register file: the single writer that drives the file's one write port.
- Arbitrates writeback requests from three producers (ALU, load/store unit, mul/div unit) using valid/ready handshakes.
- Drives one registered write per cycle and suppresses writes to x0.
- Maintains a per-register pending scoreboard so issue logic can detect RAW hazards against in-flight results.

Parameters:
- XLEN, 32, data width of the write port and of every writeback source.
- STARVE_LIMIT, 4, consecutive stalled cycles after which LSU or MDU is promoted to urgent priority (range 1..15).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- alu_valid  input  1  ALU has a result.
- alu_ready  output  1  ALU request granted this cycle.
- alu_rd  input  5  ALU destination register.
- alu_data  input  XLEN  ALU result.
- lsu_valid  input  1  LSU has a result.
- lsu_ready  output  1  LSU request granted.
- lsu_rd  input  5  LSU destination register.
- lsu_data  input  XLEN  LSU result.
- mdu_valid  input  1  MDU has a result.
- mdu_ready  output  1  MDU request granted.
- mdu_rd  input  5  MDU destination register.
- mdu_data  input  XLEN  MDU result.
- iss_valid  input  1  an instruction with destination iss_rd issues this cycle.
- iss_rd  input  5  destination of the issuing instruction.
- pending  output  32  bit i = 1 while a write to register i is outstanding.
- rf_write  output  1  write enable to the register file.
- rf_waddr  output  5  write address to the register file.
- rf_wdata  output  XLEN  write data to the register file.

Behaviour:
- Reset (rst low, asynchronous): rf_write=0, rf_waddr=0, rf_wdata=0, pending=0, both starvation counters=0. Mid-operation reset discards any granted-but-uncommitted write.
- Handshake: a transfer occurs when X_valid && X_ready. The ready outputs are combinational from the current valids and counters. At most one ready is high per cycle. A ready is never high unless its own valid is high. Sources must hold rd/data stable while valid && !ready.
- Priority, highest first:
  1. MDU urgent
  2. LSU urgent
  3. ALU
  4. LSU
  5. MDU
- Urgent means the source's wait counter equals STARVE_LIMIT. If both are urgent, MDU wins.
- Wait counters (LSU, MDU, each 4 bits):
  - Increment when valid && !ready.
  - Saturate at STARVE_LIMIT.
  - Clear to 0 when granted or when valid is low.
- Output register: the granted rd and data are captured on the next rising edge. rf_write is 1 in the following cycle iff a grant occurred and rd != 0. Latency from grant to rf_write is one cycle. rf_waddr/rf_wdata update only on a grant and otherwise hold their value.
- x0: a grant with rd=0 completes the handshake normally but produces rf_write=0. pending[0] is always 0.
- Scoreboard:
  - Set: on iss_valid with iss_rd != 0, set pending[iss_rd] at the clock edge.
  - Clear: when rf_write=1, clear pending[rf_waddr] at the same edge the register file commits the data. A consumer therefore sees pending=0 only once the file already holds the new value.
  - Set and clear of the same register at the same edge: set wins.
  - Setting an already-set bit has no extra effect; there is no per-register count, and issue logic must not issue a second writer to a pending register.
- No requests: all readies 0, rf_write=0 next cycle, counters 0.

Test Plan:
- Reset with all valids high and iss_valid=1, iss_rd=5 -> all outputs 0 while rst=0; after release, first grant goes to ALU.
- alu_valid with rd=3, data=0xDEADBEEF in cycle N -> alu_ready=1 in N; rf_write=1, rf_waddr=3, rf_wdata=0xDEADBEEF in N+1; rf_write=0 in N+2 if idle.
- ALU and LSU valid continuously, LSU rd=7, data=0x11, STARVE_LIMIT=4 -> ALU granted 4 cycles, then lsu_ready=1 in the 5th cycle; LSU counter returns to 0; ALU resumes.
- ALU, LSU and MDU valid continuously -> MDU is never granted until its counter reaches 4; once MDU is urgent it beats an urgent LSU; no cycle has two readies high.
- iss_valid with iss_rd=9 at cycle N -> pending[9]=1 from N+1. mdu grant rd=9 at M -> rf_write at M+1 -> pending[9]=0 from M+2. With a new issue of rd=9 at M+1, pending[9] stays 1.
- lsu grant rd=0, data=0xFFFF -> handshake completes, rf_write stays 0, pending[0] stays 0; iss_rd=0 never sets pending.
